// File: rtl/stream_program_loader.sv
// Streams an image from a valid/ready source into instruction memory from a programmable base, with optional trailing checksum.
// One word per two cycles (accept, then write); in_ready drops while a write is pending and outside RECV/CHECK.
module stream_program_loader #(
  parameter int unsigned WORD_SIZE     = 16,
  parameter int unsigned MEM_ADDR_SIZE = 8,
  parameter int unsigned MEM_SIZE      = 256,
  parameter int unsigned CHECKSUM_EN   = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start_load,
  input  logic [MEM_ADDR_SIZE-1:0] base_addr,
  input  logic [MEM_ADDR_SIZE:0]   load_len,
  input  logic                     abort,
  input  logic [WORD_SIZE-1:0]     in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_write,
  output logic                     busy,
  output logic                     load_complete,
  output logic                     load_error,
  output logic [1:0]               err_code,
  output logic [MEM_ADDR_SIZE:0]   words_written
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERROR} state_t;

  localparam int unsigned EW = MEM_ADDR_SIZE + 2;

  state_t                   state;
  logic [MEM_ADDR_SIZE:0]   len_q;
  logic [WORD_SIZE-1:0]     acc;
  logic [WORD_SIZE-1:0]     acc_sum;
  logic [EW-1:0]            end_addr;
  logic [MEM_ADDR_SIZE:0]   ww_next;

  assign in_ready = (state == RECV) || (state == CHECK);
  assign busy     = in_ready || (state == WRITE);
  assign acc_sum  = acc + in_data;
  assign end_addr = {2'b00, base_addr} + {1'b0, load_len};
  assign ww_next  = words_written + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      len_q          <= '0;
      acc            <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      load_complete  <= 1'b0;
      load_error     <= 1'b0;
      err_code       <= 2'd0;
      words_written  <= '0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_load) begin
            len_q         <= load_len;
            mem_addr      <= base_addr;
            acc           <= '0;
            words_written <= '0;
            load_complete <= 1'b0;
            load_error    <= 1'b0;
            err_code      <= 2'd0;
            // Reject images that would run past the end of memory before any write.
            if (end_addr > EW'(MEM_SIZE)) begin
              state      <= ERROR;
              load_error <= 1'b1;
              err_code   <= 2'd1;
            end else if (load_len == '0) begin
              if (CHECKSUM_EN != 0) begin
                state <= CHECK;
              end else begin
                state         <= DONE;
                load_complete <= 1'b1;
              end
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (abort) begin
            state      <= ERROR;
            load_error <= 1'b1;
            err_code   <= 2'd3;
          end else if (in_valid) begin
            mem_write_data <= in_data;
            mem_write      <= 1'b1;
            acc            <= acc_sum;
            state          <= WRITE;
          end
        end
        WRITE: begin
          // The strobe is already on the bus this cycle, so the word counts even on abort.
          words_written <= ww_next;
          if (abort) begin
            state      <= ERROR;
            load_error <= 1'b1;
            err_code   <= 2'd3;
          end else if (ww_next == len_q) begin
            if (CHECKSUM_EN != 0) begin
              state <= CHECK;
            end else begin
              state         <= DONE;
              load_complete <= 1'b1;
            end
          end else begin
            mem_addr <= mem_addr + 1'b1;
            state    <= RECV;
          end
        end
        CHECK: begin
          if (abort) begin
            state      <= ERROR;
            load_error <= 1'b1;
            err_code   <= 2'd3;
          end else if (in_valid) begin
            if (acc_sum == '0) begin
              state         <= DONE;
              load_complete <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
              err_code   <= 2'd2;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_program_loader.sv
// Drives two loaders (checksum off / on) with randomized streams and compares against a per-load outcome model.
module tb_stream_program_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start_load [2];
  logic [7:0]  base_addr [2];
  logic [8:0]  load_len [2];
  logic        abort [2];
  logic [15:0] in_data [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic [7:0]  mem_addr [2];
  logic [15:0] mem_write_data [2];
  logic        mem_write [2];
  logic        busy [2];
  logic        load_complete [2];
  logic        load_error [2];
  logic [1:0]  err_code [2];
  logic [8:0]  words_written [2];

  int checks = 0;
  int errors = 0;

  logic [7:0]  log_addr [2][4096];
  logic [15:0] log_data [2][4096];
  int          log_n [2] = '{0, 0};

  always #5 clock = ~clock;

  stream_program_loader #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .MEM_SIZE(256), .CHECKSUM_EN(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start_load(start_load[0]), .base_addr(base_addr[0]),
    .load_len(load_len[0]), .abort(abort[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .mem_addr(mem_addr[0]), .mem_write_data(mem_write_data[0]),
    .mem_write(mem_write[0]), .busy(busy[0]), .load_complete(load_complete[0]),
    .load_error(load_error[0]), .err_code(err_code[0]), .words_written(words_written[0]));

  stream_program_loader #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .MEM_SIZE(256), .CHECKSUM_EN(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start_load(start_load[1]), .base_addr(base_addr[1]),
    .load_len(load_len[1]), .abort(abort[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .mem_addr(mem_addr[1]), .mem_write_data(mem_write_data[1]),
    .mem_write(mem_write[1]), .busy(busy[1]), .load_complete(load_complete[1]),
    .load_error(load_error[1]), .err_code(err_code[1]), .words_written(words_written[1]));

  // Write strobes are one cycle wide, so each shows up at exactly one falling edge.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_write[d] === 1'b1) begin
        log_addr[d][log_n[d] % 4096] = mem_addr[d];
        log_data[d][log_n[d] % 4096] = mem_write_data[d];
        log_n[d]++;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input int d, input logic [15:0] w);
    bit done = 0;
    in_valid[d] = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      in_data[d] = 16'($urandom);
      step();
    end
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clock);
      if (in_ready[d]) begin
        step();
        done = 1;
      end
    end
    in_valid[d] = 1'b0;
    in_data[d]  = 16'($urandom);
    if (!done) check_val("xfer_timeout", 32'd1, 32'd0);
  endtask

  // mode 1 uses the image 1,2,3,...; chk_good=0 forces a checksum that cannot cancel the sum.
  task automatic run_load(input int d, input int base, input int len, input bit chk_good,
                          input int abort_at, input bit abort_valid, input int mode);
    logic [15:0] w [$];
    logic [15:0] sum = 16'h0;
    logic [15:0] chk;
    bit          ovf;
    int          n, snap, bad, t;
    int          exp_code;
    bit          exp_done;
    for (int i = 0; i < len; i++) begin
      w.push_back(mode == 1 ? 16'(i + 1) : 16'($urandom));
      sum += w[i];
    end
    chk = chk_good ? (16'h0 - sum) : (16'h0 - sum + 16'($urandom_range(1, 65535)));
    ovf = (base + len) > 256;
    n   = ovf ? 0 : (abort_at >= 0 ? abort_at : len);
    if (ovf)                exp_code = 1;
    else if (abort_at >= 0) exp_code = 3;
    else if (d == 1 && !chk_good) exp_code = 2;
    else                    exp_code = 0;
    exp_done = (exp_code == 0);

    snap = log_n[d];
    start_load[d] = 1'b1;
    base_addr[d]  = 8'(base);
    load_len[d]   = 9'(len);
    step();
    start_load[d] = 1'b0;
    base_addr[d]  = 8'($urandom);
    load_len[d]   = 9'($urandom);

    if (ovf) begin
      check_val("ovf_now", {in_ready[d], busy[d], load_error[d], err_code[d]}, {1'b0, 1'b0, 1'b1, 2'd1});
    end else if (len == 0 && d == 0) begin
      check_val("len0_done", {busy[d], load_complete[d]}, {1'b0, 1'b1});
    end else begin
      check_val("armed", {busy[d], load_complete[d], load_error[d], err_code[d], words_written[d]},
                {1'b1, 1'b0, 1'b0, 2'd0, 9'd0});
    end

    if (!ovf) begin
      for (int i = 0; i < n; i++) send_word(d, w[i]);
      if (abort_at >= 0) begin
        if (abort_valid && n > 0) begin
          step();
          in_valid[d] = 1'b1;
          in_data[d]  = 16'($urandom);
        end
        abort[d] = 1'b1;
        step();
        abort[d]    = 1'b0;
        in_valid[d] = 1'b0;
      end else if (d == 1) begin
        send_word(d, chk);
      end
    end

    t = 0;
    while (busy[d] && t < 20) begin
      step();
      t++;
    end
    repeat (2) step();

    check_val("end_state", {busy[d], in_ready[d], load_complete[d], load_error[d], err_code[d]},
              {1'b0, 1'b0, exp_done, !exp_done, 2'(exp_code)});
    check_val("words_written", words_written[d], 32'(n));
    check_val("write_count", 32'(log_n[d] - snap), 32'(n));
    bad = 0;
    for (int i = 0; i < n && i < log_n[d] - snap; i++) begin
      if (log_addr[d][(snap + i) % 4096] !== 8'(base + i) || log_data[d][(snap + i) % 4096] !== w[i]) bad++;
    end
    check_val("write_content", 32'(bad), 32'd0);
  endtask

  initial begin
    int snap;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_load[d] = 1'b0; base_addr[d] = '0; load_len[d] = '0;
      abort[d] = 1'b0; in_data[d] = '0; in_valid[d] = 1'b0;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++)
      check_val("reset_outs", {in_ready[d], mem_addr[d], mem_write_data[d], mem_write[d], busy[d],
                load_complete[d], load_error[d], err_code[d], words_written[d]}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    run_load(1, 'h10, 4, 1, -1, 0, 1);    // good checksum 0xFFF6
    run_load(1, 'h10, 4, 0, -1, 0, 1);    // bad checksum
    run_load(1, 'hFE, 3, 1, -1, 0, 0);    // overflow
    run_load(1, 'h20, 5, 1, 2, 0, 0);     // abort after 2nd transfer
    run_load(1, 'h20, 5, 1, 1, 1, 0);     // abort wins over a same-cycle word
    run_load(1, 'h30, 3, 1, -1, 0, 0);    // re-armed after error
    run_load(1, 'h00, 0, 1, -1, 0, 0);    // checksum-only image

    // Asynchronous reset in the middle of a load.
    snap = log_n[1];
    start_load[1] = 1'b1; base_addr[1] = 8'h40; load_len[1] = 9'd4;
    step();
    start_load[1] = 1'b0;
    send_word(1, 16'h1234);
    step();
    #2 reset_n = 1'b0;
    #1 check_val("async_reset", {in_ready[1], mem_addr[1], mem_write_data[1], mem_write[1], busy[1],
                 load_complete[1], load_error[1], err_code[1], words_written[1]}, 32'd0);
    repeat (3) begin
      in_valid[1] = 1'($urandom);
      in_data[1]  = 16'($urandom);
      step();
    end
    in_valid[1] = 1'b0;
    check_val("reset_no_stray", 32'(log_n[1] - snap), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    run_load(0, 0, 0, 1, -1, 0, 0);       // no checksum, empty image
    run_load(0, 0, 256, 1, -1, 0, 0);     // whole memory, no wrap
    run_load(0, 'hF0, 16, 1, -1, 0, 0);   // ends exactly at the last address

    for (int k = 0; k < 14; k++) begin
      int d, base, len, ab;
      d    = int'($urandom_range(0, 1));
      base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 255));
      len  = int'($urandom_range(0, 12));
      ab   = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_load(d, base, len, 1'($urandom_range(0, 1)), ab, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
